hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Drives per-stage load enables and flushes.

---
 rtl/hazard_ctrl_pkg.sv | 11 +
 rtl/hazard_ctrl_if.sv | 23 ++
 rtl/hz_perf_cnt.sv | 15 +
 rtl/hazard_ctrl.sv | 50 +++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types, widths and the load-use hazard test
package hazard_ctrl_pkg;
   localparam int REG_ADDR_W = 5;
   typedef enum logic {HZ_RUN, HZ_MEMWAIT} hz_state_t;
   // A load in EX whose rd feeds ID cannot be forwarded in time; x0 is never a real dependency
   function automatic logic load_use(input logic memread, input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] rs1, input logic [REG_ADDR_W-1:0] rs2,
                                     input logic use1, input logic use2);
      return memread && (rd != '0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
   endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard fields, memory handshakes and pipeline controls of the sequencer
interface hazard_ctrl_if #(parameter int CNT_W = 32);
   import hazard_ctrl_pkg::*;
   logic [REG_ADDR_W-1:0] if_id_rs1, if_id_rs2, id_ex_rd;
   logic if_id_use_rs1, if_id_use_rs2, id_ex_memread, ex_redirect;
   logic imem_req, imem_resp, dmem_req, dmem_resp;
   logic imem_rd_en, dmem_en;
   logic pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld;
   logic if_id_flush, id_ex_flush;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   modport master (
      output if_id_rs1, if_id_rs2, id_ex_rd, if_id_use_rs1, if_id_use_rs2, id_ex_memread, ex_redirect,
             imem_req, imem_resp, dmem_req, dmem_resp,
      input  imem_rd_en, dmem_en, pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld,
             if_id_flush, id_ex_flush, stall_cnt, flush_cnt
   );
   modport slave (
      input  if_id_rs1, if_id_rs2, id_ex_rd, if_id_use_rs1, if_id_use_rs2, id_ex_memread, ex_redirect,
             imem_req, imem_resp, dmem_req, dmem_resp,
      output imem_rd_en, dmem_en, pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld,
             if_id_flush, id_ex_flush, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hz_perf_cnt.sv
// hz_perf_cnt: wrapping event counter
module hz_perf_cnt #(parameter int CNT_W = 32) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign cnt_d = cnt_q + CNT_W'(inc_i);
   assign cnt_o = cnt_q;
   // count up by one per event, wrapping naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      cnt_q <= rst ? '0 : cnt_d;
   end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencer (memory freeze, load-use bubble, redirect flush)
module hazard_ctrl import hazard_ctrl_pkg::*; #(parameter int CNT_W = 32) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave bus
);
   hz_state_t state_q, state_d;
   logic imem_done_q, imem_done_d, dmem_done_q, dmem_done_d;
   logic i_ok, d_ok, mem_ok, lu, red, adv, ld_all, ld_front, stall_inc, flush_inc;
   // memory-done terms, hazard decode and next state of the freeze FSM
   always_comb begin
      i_ok        = !bus.imem_req | bus.imem_resp | imem_done_q;
      d_ok        = !bus.dmem_req | bus.dmem_resp | dmem_done_q;
      mem_ok      = i_ok & d_ok;
      lu          = load_use(bus.id_ex_memread, bus.id_ex_rd, bus.if_id_rs1, bus.if_id_rs2,
                             bus.if_id_use_rs1, bus.if_id_use_rs2);
      red         = bus.ex_redirect;
      adv         = (state_q == HZ_MEMWAIT) & mem_ok;
      state_d     = mem_ok ? HZ_RUN : HZ_MEMWAIT;
      imem_done_d = adv ? 1'b0 : imem_done_q | (bus.imem_resp & !mem_ok);
      dmem_done_d = adv ? 1'b0 : dmem_done_q | (bus.dmem_resp & !mem_ok);
      ld_all      = !rst & mem_ok;
      ld_front    = ld_all & (red | !lu);
      stall_inc   = !rst & (!mem_ok | (!red & lu));
      flush_inc   = ld_all & red;
   end
   // freeze FSM and latched responses; a reset drops any response already captured
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HZ_RUN;
         imem_done_q <= 1'b0;
         dmem_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         imem_done_q <= imem_done_d;
         dmem_done_q <= dmem_done_d;
      end
   end
   assign bus.imem_rd_en  = !rst & bus.imem_req & !imem_done_q;
   assign bus.dmem_en     = !rst & bus.dmem_req & !dmem_done_q;
   assign bus.pc_ld       = ld_front;
   assign bus.if_id_ld    = ld_front;
   assign bus.id_ex_ld    = ld_all;
   assign bus.ex_mem_ld   = ld_all;
   assign bus.mem_wb_ld   = ld_all;
   assign bus.if_id_flush = rst | (mem_ok & red);
   assign bus.id_ex_flush = rst | (mem_ok & (red | lu));
   hz_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc_i(stall_inc), .cnt_o(bus.stall_cnt));
   hz_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc_i(flush_inc), .cnt_o(bus.flush_cnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for the pipeline sequencer
module tb_hazard_ctrl;
   typedef struct packed {
      logic rst;
      logic [4:0] rs1, rs2;
      logic u1, u2, mr;
      logic [4:0] rd;
      logic red, ireq, iresp, dreq, dresp;
   } stim_t;
   typedef struct packed {
      stim_t s;
      logic [8:0] o;
      logic [7:0] sc, fc;
   } row_t;
   // outputs as {imem_rd_en, dmem_en, pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
   localparam logic [6:0] NRM = 7'b1111100, STL = 7'b0000000, LU = 7'b0011101,
                          RED = 7'b1111111, RST = 7'b0000011;
   logic clk = 1'b0;
   logic rst;
   logic w_inc;
   logic [1:0] w_cnt;
   logic [8:0] exp_q[$];
   int total = 0;
   int bad = 0;
   hazard_ctrl_if #(.CNT_W(32)) bus();
   hazard_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   hz_perf_cnt #(.CNT_W(2)) u_wrap (.clk(clk), .rst(rst), .inc_i(w_inc), .cnt_o(w_cnt));
   always #5 clk = ~clk;

   function automatic stim_t st(logic r, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2, logic mr,
                                logic [4:0] rd, logic red, logic ireq, logic iresp, logic dreq, logic dresp);
      return '{r, rs1, rs2, u1, u2, mr, rd, red, ireq, iresp, dreq, dresp};
   endfunction

   function automatic logic [8:0] outs();
      return {bus.imem_rd_en, bus.dmem_en, bus.pc_ld, bus.if_id_ld, bus.id_ex_ld, bus.ex_mem_ld,
              bus.mem_wb_ld, bus.if_id_flush, bus.id_ex_flush};
   endfunction

   task automatic apply(input stim_t s);
      rst = s.rst;
      bus.if_id_rs1 = s.rs1;
      bus.if_id_rs2 = s.rs2;
      bus.if_id_use_rs1 = s.u1;
      bus.if_id_use_rs2 = s.u2;
      bus.id_ex_memread = s.mr;
      bus.id_ex_rd = s.rd;
      bus.ex_redirect = s.red;
      bus.imem_req = s.ireq;
      bus.imem_resp = s.iresp;
      bus.dmem_req = s.dreq;
      bus.dmem_resp = s.dresp;
   endtask

   task automatic do_reset();
      apply(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
   endtask

   task automatic test_reset();
      row_t rows[$];
      logic [8:0] e, got;
      for (int i = 0; i < 3; i++) rows.push_back('{st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {2'b00, RST}, 8'd0, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {2'b00, NRM}, 8'd0, 8'd0});
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i].s);
         exp_q.push_back(rows[i].o);
         #4;
         e = exp_q.pop_front();
         got = outs();
         total++;
         if (got !== e) begin bad++; $display("FAIL reset[%0d] outs: got %b want %b", i, got, e); end
         @(negedge clk);
         total++;
         if (bus.stall_cnt !== 32'(rows[i].sc) || bus.flush_cnt !== 32'(rows[i].fc)) begin
            bad++; $display("FAIL reset[%0d] cnt: got %0d/%0d want %0d/%0d", i, bus.stall_cnt, bus.flush_cnt, rows[i].sc, rows[i].fc);
         end
      end
   endtask

   task automatic test_load_use();
      row_t rows[$];
      logic [8:0] e, got;
      do_reset();
      rows.push_back('{st(0, 5, 1, 1, 0, 1, 5, 0, 0, 0, 0, 0), {2'b00, LU}, 8'd1, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {2'b00, NRM}, 8'd1, 8'd0});
      rows.push_back('{st(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), {2'b00, NRM}, 8'd1, 8'd0});
      rows.push_back('{st(0, 3, 7, 0, 1, 1, 7, 0, 0, 0, 0, 0), {2'b00, LU}, 8'd2, 8'd0});
      rows.push_back('{st(0, 7, 3, 0, 1, 1, 7, 0, 0, 0, 0, 0), {2'b00, NRM}, 8'd2, 8'd0});
      rows.push_back('{st(0, 5, 0, 1, 0, 0, 5, 0, 0, 0, 0, 0), {2'b00, NRM}, 8'd2, 8'd0});
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i].s);
         exp_q.push_back(rows[i].o);
         #4;
         e = exp_q.pop_front();
         got = outs();
         total++;
         if (got !== e) begin bad++; $display("FAIL load_use[%0d] outs: got %b want %b", i, got, e); end
         @(negedge clk);
         total++;
         if (bus.stall_cnt !== 32'(rows[i].sc) || bus.flush_cnt !== 32'(rows[i].fc)) begin
            bad++; $display("FAIL load_use[%0d] cnt: got %0d/%0d want %0d/%0d", i, bus.stall_cnt, bus.flush_cnt, rows[i].sc, rows[i].fc);
         end
      end
   endtask

   task automatic test_mem_stall();
      row_t rows[$];
      logic [8:0] e, got;
      do_reset();
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), {2'b11, STL}, 8'd1, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), {2'b11, STL}, 8'd2, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), {2'b11, STL}, 8'd3, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), {2'b01, STL}, 8'd4, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), {2'b01, STL}, 8'd5, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1), {2'b01, NRM}, 8'd5, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {2'b00, NRM}, 8'd5, 8'd0});
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i].s);
         exp_q.push_back(rows[i].o);
         #4;
         e = exp_q.pop_front();
         got = outs();
         total++;
         if (got !== e) begin bad++; $display("FAIL mem_stall[%0d] outs: got %b want %b", i, got, e); end
         @(negedge clk);
         total++;
         if (bus.stall_cnt !== 32'(rows[i].sc) || bus.flush_cnt !== 32'(rows[i].fc)) begin
            bad++; $display("FAIL mem_stall[%0d] cnt: got %0d/%0d want %0d/%0d", i, bus.stall_cnt, bus.flush_cnt, rows[i].sc, rows[i].fc);
         end
      end
   endtask

   task automatic test_redirect();
      row_t rows[$];
      logic [8:0] e, got;
      do_reset();
      rows.push_back('{st(0, 5, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0), {2'b00, RED}, 8'd0, 8'd1});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {2'b00, NRM}, 8'd0, 8'd1});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), {2'b00, RED}, 8'd0, 8'd2});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {2'b00, NRM}, 8'd0, 8'd2});
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i].s);
         exp_q.push_back(rows[i].o);
         #4;
         e = exp_q.pop_front();
         got = outs();
         total++;
         if (got !== e) begin bad++; $display("FAIL redirect[%0d] outs: got %b want %b", i, got, e); end
         @(negedge clk);
         total++;
         if (bus.stall_cnt !== 32'(rows[i].sc) || bus.flush_cnt !== 32'(rows[i].fc)) begin
            bad++; $display("FAIL redirect[%0d] cnt: got %0d/%0d want %0d/%0d", i, bus.stall_cnt, bus.flush_cnt, rows[i].sc, rows[i].fc);
         end
      end
   endtask

   task automatic test_redirect_in_stall();
      row_t rows[$];
      logic [8:0] e, got;
      do_reset();
      for (int i = 0; i < 4; i++)
         rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), {2'b01, STL}, 8'(i + 1), 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1), {2'b01, RED}, 8'd4, 8'd1});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {2'b00, NRM}, 8'd4, 8'd1});
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i].s);
         exp_q.push_back(rows[i].o);
         #4;
         e = exp_q.pop_front();
         got = outs();
         total++;
         if (got !== e) begin bad++; $display("FAIL redir_stall[%0d] outs: got %b want %b", i, got, e); end
         @(negedge clk);
         total++;
         if (bus.stall_cnt !== 32'(rows[i].sc) || bus.flush_cnt !== 32'(rows[i].fc)) begin
            bad++; $display("FAIL redir_stall[%0d] cnt: got %0d/%0d want %0d/%0d", i, bus.stall_cnt, bus.flush_cnt, rows[i].sc, rows[i].fc);
         end
      end
   endtask

   task automatic test_rst_mid_stall();
      row_t rows[$];
      logic [8:0] e, got;
      do_reset();
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), {2'b11, STL}, 8'd1, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), {2'b11, STL}, 8'd2, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), {2'b01, STL}, 8'd3, 8'd0});
      rows.push_back('{st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), {2'b00, RST}, 8'd0, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), {2'b11, STL}, 8'd1, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1), {2'b11, NRM}, 8'd1, 8'd0});
      rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {2'b00, NRM}, 8'd1, 8'd0});
      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i].s);
         exp_q.push_back(rows[i].o);
         #4;
         e = exp_q.pop_front();
         got = outs();
         total++;
         if (got !== e) begin bad++; $display("FAIL rst_stall[%0d] outs: got %b want %b", i, got, e); end
         @(negedge clk);
         total++;
         if (bus.stall_cnt !== 32'(rows[i].sc) || bus.flush_cnt !== 32'(rows[i].fc)) begin
            bad++; $display("FAIL rst_stall[%0d] cnt: got %0d/%0d want %0d/%0d", i, bus.stall_cnt, bus.flush_cnt, rows[i].sc, rows[i].fc);
         end
      end
   endtask

   task automatic test_wrap();
      logic [1:0] e;
      w_inc = 1'b0;
      do_reset();
      apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 6; i++) begin
         w_inc = 1'b1;
         exp_q.push_back(9'((i + 1) % 4));
         @(negedge clk);
         e = 2'(exp_q.pop_front());
         total++;
         if (w_cnt !== e) begin bad++; $display("FAIL wrap[%0d]: got %0d want %0d", i, w_cnt, e); end
      end
      w_inc = 1'b0;
   endtask

   initial begin
      w_inc = 1'b0;
      test_reset();
      test_load_use();
      test_mem_stall();
      test_redirect();
      test_redirect_in_stall();
      test_rst_mid_stall();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
